pc_sequencer: RTL and testbench

//  Program-counter stage directly upstream of the control unit. Holds the PC that addresses instruction

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter, run-state FSM and confirm-button synchroniser.
// Sits just upstream of the control unit and gates datapath writes.
module pc_sequencer #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump,
    input  logic              branch,
    input  logic              jr,
    input  logic              fHalt,
    input  logic              fHaltIN,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [15:0]       branch_offset,
    input  logic [31:0]       jr_target,
    input  logic              confirm_button,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              commit,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1_q, s2_q, s3_q;

    logic              confirm_pulse;
    logic              commit_w;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;

    assign pc_inc        = pc_q + ADDR_W'(1);
    assign br_off        = ADDR_W'($signed(branch_offset));
    assign br_tgt        = pc_inc + br_off;
    assign confirm_pulse = s2_q & ~s3_q;

    always_comb begin
        commit_w = 1'b0;
        if (state_q == ST_RUN && !fHalt && !fHaltIN)
            commit_w = 1'b1;
        if (state_q == ST_WAIT && confirm_pulse)
            commit_w = 1'b1;
        commit_w = commit_w & rst_n;
    end

    always_comb begin
        pc_d = pc_q;
        if (commit_w) begin
            if (jr)
                pc_d = ADDR_W'(jr_target);
            else if (jump)
                pc_d = jump_target;
            else if (branch)
                pc_d = br_tgt;
            else
                pc_d = pc_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (fHalt)
                    state_d = ST_HALT;
                else if (fHaltIN)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (confirm_pulse)
                    state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (commit_w && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Sync chain resets high so a button held through reset gives no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            s1_q    <= confirm_button;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    assign pc            = pc_q;
    assign pc_plus1      = pc_inc;
    assign commit        = commit_w;
    assign state         = state_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: flow-control vector table plus
// LOADIN / HALT / reset sequences, with a queued expectation scoreboard.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump, branch, jr, fHalt, fHaltIN;
    logic [9:0]  jump_target;
    logic [15:0] branch_offset;
    logic [31:0] jr_target;
    logic        confirm_button;
    logic [9:0]  pc, pc_plus1;
    logic        commit;
    logic [1:0]  state;
    logic [15:0] retired_count;
    logic [9:0]  s_pc, s_pc_plus1;
    logic        s_commit;
    logic [1:0]  s_state;
    logic [3:0]  s_retired;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk(clk), .rst_n(rst_n),
        .jump(jump), .branch(branch), .jr(jr),
        .fHalt(fHalt), .fHaltIN(fHaltIN),
        .jump_target(jump_target),
        .branch_offset(branch_offset),
        .jr_target(jr_target),
        .confirm_button(confirm_button),
        .pc(pc), .pc_plus1(pc_plus1),
        .commit(commit), .state(state),
        .retired_count(retired_count)
    );

    pc_sequencer #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .jump(jump), .branch(branch), .jr(jr),
        .fHalt(fHalt), .fHaltIN(fHaltIN),
        .jump_target(jump_target),
        .branch_offset(branch_offset),
        .jr_target(jr_target),
        .confirm_button(confirm_button),
        .pc(s_pc), .pc_plus1(s_pc_plus1),
        .commit(s_commit), .state(s_state),
        .retired_count(s_retired)
    );

    typedef struct {
        logic        jump, branch, jr;
        logic [9:0]  jt;
        logic [15:0] off;
        logic [31:0] jrt;
        logic [9:0]  exp_pc;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic [1:0] st;
    } exp_t;

    vec_t vecs[14];
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    logic [9:0] prev;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; inputs are set by the caller.
    task automatic cyc(input string nm, input logic exp_c,
                       input logic [9:0] epc, input logic [1:0] est);
        exp_t e;
        #1;
        chk({nm, " commit"}, {31'd0, commit}, {31'd0, exp_c});
        sbq.push_back('{nm, epc, est});
        if (exp_c) exp_cnt++;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.name, " pc"}, {22'd0, pc}, {22'd0, e.pc});
        chk({e.name, " state"}, {30'd0, state}, {30'd0, e.st});
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string nm);
        int sat;
        sat = (exp_cnt > 15) ? 15 : exp_cnt;
        chk({nm, " count"}, {16'd0, retired_count}, exp_cnt);
        chk({nm, " satcount"}, {28'd0, s_retired}, sat);
    endtask

    task automatic chk_reset(input string nm);
        #1;
        chk({nm, " pc"}, {22'd0, pc}, 32'd0);
        chk({nm, " state"}, {30'd0, state}, 32'd0);
        chk({nm, " commit"}, {31'd0, commit}, 32'd0);
        chk({nm, " count"}, {16'd0, retired_count}, 32'd0);
    endtask

    // Button must have been low long enough for the chain to clear.
    task automatic confirm(input string nm, input logic [9:0] p);
        confirm_button = 1'b1;
        cyc({nm, " e1"}, 1'b0, p, 2'd2);
        cyc({nm, " e2"}, 1'b0, p, 2'd2);
        fHaltIN = 1'b0;
        cyc({nm, " e3"}, 1'b1, 10'(p + 1), 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 1, 0, 10'h000, 16'hFFFD, 32'h0, 10'h003};
        vecs[1]  = '{1, 0, 0, 10'h02A, 16'h0000, 32'h0, 10'h02A};
        vecs[2]  = '{0, 0, 1, 10'h000, 16'h0000, 32'h407, 10'h007};
        vecs[3]  = '{1, 0, 1, 10'h100, 16'h0000, 32'h55, 10'h055};
        vecs[4]  = '{1, 1, 0, 10'h200, 16'h0005, 32'h0, 10'h200};
        vecs[5]  = '{0, 1, 0, 10'h000, 16'h0010, 32'h0, 10'h211};
        vecs[6]  = '{0, 1, 0, 10'h000, 16'h8000, 32'h0, 10'h212};
        vecs[7]  = '{1, 0, 0, 10'h3FF, 16'h0000, 32'h0, 10'h3FF};
        vecs[8]  = '{0, 0, 0, 10'h000, 16'h0000, 32'h0, 10'h000};
        vecs[9]  = '{1, 0, 0, 10'h002, 16'h0000, 32'h0, 10'h002};
        vecs[10] = '{0, 1, 0, 10'h000, 16'hFFFB, 32'h0, 10'h3FE};
        vecs[11] = '{0, 1, 0, 10'h000, 16'h0001, 32'h0, 10'h000};
        vecs[12] = '{0, 0, 1, 10'h000, 16'h0000, 32'hFFFF_FFFF,
                     10'h3FF};
        vecs[13] = '{0, 0, 0, 10'h000, 16'h0000, 32'h0, 10'h000};

        rst_n = 1'b0;
        jump = 0; branch = 0; jr = 0; fHalt = 0; fHaltIN = 0;
        jump_target = '0; branch_offset = '0; jr_target = '0;
        confirm_button = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset("t1 rst");
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++)
            cyc("t1 idle", 1'b1, 10'(i), 2'd0);
        chk_cnt("t1");
        #2 rst_n = 1'b0;
        chk_reset("t1 midrst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;

        for (int i = 1; i <= 5; i++)
            cyc("t2 idle", 1'b1, 10'(i), 2'd0);
        prev = 10'd5;
        for (int i = 0; i < 14; i++) begin
            jump = vecs[i].jump;
            branch = vecs[i].branch;
            jr = vecs[i].jr;
            jump_target = vecs[i].jt;
            branch_offset = vecs[i].off;
            jr_target = vecs[i].jrt;
            chk($sformatf("t2 v%0d pc_plus1", i), {22'd0, pc_plus1},
                {22'd0, 10'(prev + 1)});
            cyc($sformatf("t2 v%0d", i), 1'b1, vecs[i].exp_pc, 2'd0);
            prev = vecs[i].exp_pc;
        end
        jump = 0; branch = 0; jr = 0;
        chk_cnt("t2");

        jump = 1; jump_target = 10'd7;
        cyc("t3 j7", 1'b1, 10'd7, 2'd0);
        jump = 0;
        fHaltIN = 1'b1;
        cyc("t3 enter", 1'b0, 10'd7, 2'd2);
        repeat (20) cyc("t3 wait", 1'b0, 10'd7, 2'd2);
        confirm("t3 conf", 10'd7);
        fHaltIN = 1'b1;
        cyc("t3 enter2", 1'b0, 10'd8, 2'd2);
        repeat (50) cyc("t3 held", 1'b0, 10'd8, 2'd2);
        confirm_button = 1'b0;
        repeat (3) cyc("t3 rel", 1'b0, 10'd8, 2'd2);
        confirm("t3 conf2", 10'd8);
        confirm_button = 1'b0;
        for (int i = 10; i <= 12; i++)
            cyc("t3 run", 1'b1, 10'(i), 2'd0);
        confirm_button = 1'b1;
        cyc("t3 pre1", 1'b1, 10'd13, 2'd0);
        cyc("t3 pre2", 1'b1, 10'd14, 2'd0);
        fHaltIN = 1'b1;
        cyc("t3 entrypulse", 1'b0, 10'd14, 2'd2);
        repeat (5) cyc("t3 ignored", 1'b0, 10'd14, 2'd2);
        confirm_button = 1'b0;
        repeat (3) cyc("t3 rel2", 1'b0, 10'd14, 2'd2);
        confirm("t3 conf3", 10'd14);
        confirm_button = 1'b0;
        chk_cnt("t3");

        jump = 1; jump_target = 10'd9;
        cyc("t4 j9", 1'b1, 10'd9, 2'd0);
        jump = 0;
        fHalt = 1'b1; fHaltIN = 1'b1;
        cyc("t4 halt", 1'b0, 10'd9, 2'd1);
        fHalt = 1'b0; fHaltIN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            confirm_button = ~confirm_button;
            jump = 1; jump_target = 10'h055;
            cyc("t4 halted", 1'b0, 10'd9, 2'd1);
        end
        chk_cnt("t4");
        jump = 0;
        rst_n = 1'b0;
        chk_reset("t4 rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        cyc("t4 after", 1'b1, 10'd1, 2'd0);

        fHaltIN = 1'b1;
        cyc("t6 enter", 1'b0, 10'd1, 2'd2);
        confirm_button = 1'b1;
        cyc("t6 press", 1'b0, 10'd1, 2'd2);
        rst_n = 1'b0;
        chk_reset("t6 rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        cyc("t6 enter2", 1'b0, 10'd0, 2'd2);
        repeat (10) cyc("t6 held", 1'b0, 10'd0, 2'd2);
        confirm_button = 1'b0;
        repeat (3) cyc("t6 rel", 1'b0, 10'd0, 2'd2);
        confirm("t6 conf", 10'd0);
        confirm_button = 1'b0;
        chk_cnt("t6");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
